// File: rtl/flag_vend_ctrl_pkg.sv
// Shared types and constants for the flag vending controller.
// Imported by the tick synchronizer and the top-level controller.
package flag_vend_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  localparam int STATE_W      = 2;
  // sync1, sync2, history
  localparam int SYNC_STAGES  = 3;
  // Ticks are masked until the synchronizer has refilled after reset.
  localparam int PRIME_CYCLES = 3;

endpackage

// File: rtl/flag_vend_ctrl_tick.sv
// Brings the slow 1 Hz square wave into the clk domain.
// Emits one registered pulse per rising edge, masked for a few cycles after reset.
module sec_tick_sync
  import flag_vend_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clk_1hz,
  output logic sec_tick
);

  // [0]=sync1, [1]=sync2, [2]=previous sync2 for edge detect
  logic [SYNC_STAGES-1:0]  sync_pipe;
  logic [PRIME_CYCLES-1:0] prime_pipe;
  logic                    primed;

  assign primed = prime_pipe[PRIME_CYCLES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe  <= '0;
      prime_pipe <= '0;
      sec_tick   <= 1'b0;
    end else begin
      sync_pipe  <= {sync_pipe[SYNC_STAGES-2:0], clk_1hz};
      prime_pipe <= {prime_pipe[PRIME_CYCLES-2:0], 1'b1};
      sec_tick   <= sync_pipe[1] & ~sync_pipe[2] & primed;
    end
  end

endmodule

// File: rtl/flag_vend_ctrl.sv
// Flag vending controller: credit counter, vend FSM and seconds countdown,
// all timed from the synchronized 1 Hz tick. Every output is a flop.
module flag_vend_ctrl
  import flag_vend_ctrl_pkg::*;
#(
  parameter int PRICE         = 3,
  parameter int CREDIT_W      = 4,
  parameter int COUNT_SECS    = 5,
  parameter int COOLDOWN_SECS = 2,
  parameter int SEC_W         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_1hz,
  input  logic                coin,
  input  logic                vend_req,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [SEC_W-1:0]    secs_left,
  output logic                flag_valid,
  output logic                sec_tick
);

  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
  localparam logic [SEC_W-1:0]    COUNT_C    = SEC_W'(COUNT_SECS);
  localparam logic [SEC_W-1:0]    COOL_C     = SEC_W'(COOLDOWN_SECS);
  localparam logic [SEC_W-1:0]    ONE_S      = SEC_W'(1);

  state_e              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [SEC_W-1:0]    secs_nxt;
  logic                vend_ok;

  sec_tick_sync u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_1hz  (clk_1hz),
    .sec_tick (sec_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      credit     <= '0;
      secs_left  <= '0;
      busy       <= 1'b0;
      flag_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit     <= credit_nxt;
      secs_left  <= secs_nxt;
      busy       <= (state_nxt != ST_IDLE);
      flag_valid <= (state_nxt == ST_DISPENSE);
    end
  end

  always_comb begin
    state_nxt  = state;
    secs_nxt   = secs_left;
    credit_nxt = credit;
    // Eligibility looks at credit before any same-cycle coin lands.
    vend_ok    = (state == ST_IDLE) && vend_req && (credit >= PRICE_C);

    if (vend_ok)
      credit_nxt = credit - PRICE_C + CREDIT_W'(coin);
    else if (coin && (credit != CREDIT_MAX))
      credit_nxt = credit + CREDIT_W'(1);

    case (state)
      ST_IDLE: begin
        if (vend_ok) begin
          state_nxt = ST_COUNT;
          secs_nxt  = COUNT_C;
        end
      end
      ST_COUNT: begin
        if (sec_tick) begin
          if (secs_left == ONE_S) begin
            state_nxt = ST_DISPENSE;
            secs_nxt  = '0;
          end else if (secs_left != '0) begin
            secs_nxt  = secs_left - ONE_S;
          end
        end
      end
      ST_DISPENSE: begin
        state_nxt = ST_COOLDOWN;
        secs_nxt  = COOL_C;
      end
      ST_COOLDOWN: begin
        if (sec_tick) begin
          if (secs_left == ONE_S) begin
            state_nxt = ST_IDLE;
            secs_nxt  = '0;
          end else if (secs_left != '0) begin
            secs_nxt  = secs_left - ONE_S;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        secs_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_flag_vend_ctrl.sv
// Scoreboard bench for flag_vend_ctrl: a per-edge reference model queues the
// expected outputs, a negedge monitor pops and compares them against the DUT.
module tb_flag_vend_ctrl;

  localparam int PRICE = 3, CREDIT_W = 4, COUNT_SECS = 5, COOLDOWN_SECS = 2, SEC_W = 4;
  localparam int CMAX = (1 << CREDIT_W) - 1;
  localparam int HALF_1HZ = 20;
  localparam int P_IDLE = 0, P_COUNT = 1, P_DISP = 2, P_COOL = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clk_1hz = 1'b1;
  logic                coin = 1'b0;
  logic                vend_req = 1'b0;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic [SEC_W-1:0]    secs_left;
  logic                flag_valid;
  logic                sec_tick;

  flag_vend_ctrl #(
    .PRICE(PRICE), .CREDIT_W(CREDIT_W), .COUNT_SECS(COUNT_SECS),
    .COOLDOWN_SECS(COOLDOWN_SECS), .SEC_W(SEC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .coin(coin), .vend_req(vend_req),
    .credit(credit), .busy(busy), .secs_left(secs_left),
    .flag_valid(flag_valid), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  // 1 Hz stand-in: 40-cycle period, starts high so reset is released with it high
  initial forever begin
    repeat (HALF_1HZ) @(negedge clk);
    clk_1hz = ~clk_1hz;
  end

  typedef struct {
    int credit;
    int busy;
    int secs;
    int flag;
    int tick;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   flag_seen = 0;

  // Reference model: phase, credit, seconds, and tick derived from the raw 1 Hz samples
  int m_phase = P_IDLE, m_credit = 0, m_secs = 0, m_tick = 0, m_since = 0;
  int m_hist[$] = '{0, 0, 0, 0};

  initial forever begin
    @(posedge clk);
    begin
      int c, v, s, tick_in;
      bit acc;
      exp_t e;
      c = int'(coin); v = int'(vend_req); s = int'(clk_1hz);
      if (!rst_n) begin
        m_phase = P_IDLE; m_credit = 0; m_secs = 0; m_tick = 0; m_since = 0;
        m_hist = '{0, 0, 0, 0};
      end else begin
        tick_in = m_tick;
        acc = (m_phase == P_IDLE) && (v == 1) && (m_credit >= PRICE);
        if (acc) m_credit = m_credit - PRICE + c;
        else if (c == 1 && m_credit < CMAX) m_credit = m_credit + 1;
        case (m_phase)
          P_IDLE:  if (acc) begin m_phase = P_COUNT; m_secs = COUNT_SECS; end
          P_COUNT: if (tick_in == 1) begin
                     if (m_secs == 1) begin m_phase = P_DISP; m_secs = 0; end
                     else if (m_secs > 0) m_secs = m_secs - 1;
                   end
          P_DISP:  begin m_phase = P_COOL; m_secs = COOLDOWN_SECS; end
          default: if (tick_in == 1) begin
                     if (m_secs == 1) begin m_phase = P_IDLE; m_secs = 0; end
                     else if (m_secs > 0) m_secs = m_secs - 1;
                   end
        endcase
        m_since++;
        m_hist.push_back(s);
        void'(m_hist.pop_front());
        // rising edge seen two samples ago, and past the post-reset blanking window
        m_tick = (m_since >= 4 && m_hist[1] == 1 && m_hist[0] == 0) ? 1 : 0;
      end
      e.credit = m_credit; e.busy = (m_phase != P_IDLE) ? 1 : 0; e.secs = m_secs;
      e.flag = (m_phase == P_DISP) ? 1 : 0; e.tick = m_tick;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare on the falling edge, well away from the sampling edge
  initial forever begin
    @(negedge clk);
    if (flag_valid) flag_seen++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int'(credit) != e.credit || int'(busy) != e.busy || int'(secs_left) != e.secs ||
          int'(flag_valid) != e.flag || int'(sec_tick) != e.tick) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got credit=%0d busy=%0d secs=%0d flag=%0d tick=%0d, expected credit=%0d busy=%0d secs=%0d flag=%0d tick=%0d",
                 $time, credit, busy, secs_left, flag_valid, sec_tick,
                 e.credit, e.busy, e.secs, e.flag, e.tick);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drive for one cycle and return at the next negedge.
  task automatic step(input logic c, input logic v);
    coin = c; vend_req = v;
    @(negedge clk);
    coin = 1'b0; vend_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 600) begin @(negedge clk); n++; end
    chk(name, int'(busy), 0);
  endtask

  initial begin
    int n, f0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: released with clk_1hz high -> no tick while the synchronizer refills
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_no_tick", int'(sec_tick), 0);
      chk("t1_credit", int'(credit), 0);
    end
    repeat (10) @(negedge clk);

    // 2: full vend cycle
    f0 = flag_seen;
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("t2_credit", int'(credit), 0);
    chk("t2_busy", int'(busy), 1);
    chk("t2_secs", int'(secs_left), COUNT_SECS);
    n = 0;
    while (!flag_valid && n < 400) begin @(negedge clk); n++; end
    chk("t2_flag_seen", int'(flag_valid), 1);
    @(negedge clk);
    chk("t2_flag_one_cycle", int'(flag_valid), 0);
    chk("t2_cool_secs", int'(secs_left), COOLDOWN_SECS);
    wait_idle("t2_idle");
    chk("t2_end_secs", int'(secs_left), 0);
    chk("t2_flag_count", flag_seen - f0, 1);

    // 3: insufficient credit is ignored
    repeat (2) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t3_credit", int'(credit), 2);
    chk("t3_busy", int'(busy), 0);
    chk("t3_flag", flag_seen - f0, 1);

    // 4: coin and vend together at exactly PRICE
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t4_credit", int'(credit), 1);
    chk("t4_secs", int'(secs_left), COUNT_SECS);
    chk("t4_busy", int'(busy), 1);

    // 5: saturation, and vend during COUNT has no effect
    repeat (17) step(1'b1, 1'b0);
    chk("t5_sat", int'(credit), CMAX);
    step(1'b0, 1'b1);
    chk("t5_vend_busy", int'(credit), CMAX);
    wait_idle("t5_idle");
    chk("t5_credit_kept", int'(credit), CMAX);

    // random traffic, checked by the scoreboard
    for (int i = 0; i < 2500; i++)
      step(($urandom_range(2) == 0), ($urandom_range(7) == 0));
    wait_idle("rand_idle");

    // 6: reset in the middle of a countdown
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n = 0;
    while (!(busy && secs_left == 3) && n < 400) begin @(negedge clk); n++; end
    chk("t6_reach3", int'(secs_left), 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_credit", int'(credit), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_secs", int'(secs_left), 0);
    chk("t6_tick", int'(sec_tick), 0);
    f0 = flag_seen;
    repeat (300) @(negedge clk);
    chk("t6_no_flag", flag_seen - f0, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
